m_axi_cmd_master: RTL and testbench

- Single-outstanding AXI master that sits directly upstream of the s_axi_reg register slave.
- Converts a simple command/response interface (used by the counter control logic or a test sequencer) into single-beat AXI write (AW/W/B) and read (AR/R) transactions.
- Returns write status or read data on a response channel.
- Exactly one transaction is in flight at any time.

---
 rtl/m_axi_cmd_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_m_axi_cmd_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : m_axi_cmd_master
// Purpose  : Single-outstanding AXI master that turns a command/response
//            interface into single-beat AXI write (AW/W/B) and read (AR/R)
//            transactions. Optional watchdog: M_AXI_CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module m_axi_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_wstrb_i,
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ID_W-1:0]     wid_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output logic [ID_W-1:0]     arid_o,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [ID_W-1:0]     rid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_we_o,
    output logic [DATA_W-1:0]   rsp_data_o,
    output logic [1:0]          rsp_resp_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t              state_q,     state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ID_W-1:0]     id_cnt_q,    id_cnt_d;
    logic [ID_W-1:0]     id_q,        id_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
    logic                awvalid_q,   awvalid_d;
    logic                wvalid_q,    wvalid_d;
    logic                bready_q,    bready_d;
    logic                arvalid_q,   arvalid_d;
    logic                rready_q,    rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_we_q,    rsp_we_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic [1:0]          rsp_resp_q,  rsp_resp_d;

`ifdef M_AXI_CMD_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_active;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        id_cnt_d    = id_cnt_q;
        id_d        = id_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    id_d        = id_cnt_q;
                    id_cnt_d    = id_cnt_q + ID_W'(1);
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_wdata_i;
                    wstrb_d     = cmd_wstrb_i;
                    rsp_we_d    = cmd_we_i;
                    if (cmd_we_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR: begin
                // AW and W complete independently; a cleared valid marks that channel done.
                if (awready_i) awvalid_d = 1'b0;
                if (wready_i)  wvalid_d  = 1'b0;
                if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bvalid_i) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_resp_d  = (bid_i != id_q) ? 2'b10 : bresp_i;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_ADDR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                // Every beat overwrites; only the rlast beat ends the transfer.
                if (rvalid_i) begin
                    rsp_data_d = rdata_i;
                    rsp_resp_d = (rid_i != id_q) ? 2'b10 : rresp_i;
                    if (rlast_i) begin
                        rready_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase

`ifdef M_AXI_CMD_TIMEOUT_EN
        tmo_active = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                     (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
        if (tmo_active && (tmo_cnt_q == TMO_LAST)) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = 2'b11;
            rsp_data_d  = '0;
            state_d     = ST_RSP;
        end
        tmo_cnt_d = (tmo_active && (state_d == state_q)) ? tmo_cnt_q + CNT_W'(1) : '0;
`endif
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            id_cnt_q    <= '0;
            id_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
`ifdef M_AXI_CMD_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            id_cnt_q    <= id_cnt_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef M_AXI_CMD_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign awid_o      = id_q;
    assign awaddr_o    = addr_q;
    assign awvalid_o   = awvalid_q;
    assign wid_o       = id_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign wlast_o     = wvalid_q;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = bready_q;
    assign arid_o      = id_q;
    assign araddr_o    = addr_q;
    assign arvalid_o   = arvalid_q;
    assign rready_o    = rready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_we_o    = rsp_we_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_resp_o  = rsp_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_m_axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_axi_cmd_master
// Purpose  : Directed table-driven bench for m_axi_cmd_master with a
//            cycle-stepped AXI slave model inside the transaction tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_axi_cmd_master;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i;
    logic [3:0]  cmd_wstrb_i;
    logic [3:0]  awid_o, wid_o, bid_i, arid_o, rid_i;
    logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i, rsp_data_o;
    logic [3:0]  wstrb_o;
    logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [1:0]  bresp_i, rresp_i, rsp_resp_o;
    logic        bvalid_i, bready_o, arvalid_o, arready_i;
    logic        rlast_i, rvalid_i, rready_o;
    logic        rsp_valid_o, rsp_ready_i, rsp_we_o;

    m_axi_cmd_master dut (
        .clk(clk), .areset(areset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
        .rsp_data_o(rsp_data_o), .rsp_resp_o(rsp_resp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          d_a;      // awready delay (write) or arready delay (read)
        int          d_w;
        int          d_b;
        int          beats;
        logic        bad_id;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        int          hold;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs [8];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  exp_id = 4'd0;
    logic [3:0]  last_id;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        areset = 1'b0;
        repeat (2) tick();
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o}, 0);
        chk("rst_payload", awaddr_o | wdata_o | rsp_data_o, 0);
        areset = 1'b1;
        exp_id = 4'd0;
        tick();
    endtask

    task automatic finish_rsp(input int hold, input logic we, input logic [1:0] er, input logic [31:0] ed);
        chk("rsp_valid", rsp_valid_o, 1);
        chk("rsp_we", rsp_we_o, we);
        chk("rsp_resp", rsp_resp_o, er);
        chk("rsp_data", rsp_data_o, ed);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_rsp_valid", rsp_valid_o, 1);
            chk("hold_rsp_data", rsp_data_o, ed);
            chk("hold_rsp_resp", rsp_resp_o, er);
            chk("hold_cmd_ready", cmd_ready_o, 0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("rsp_valid_drop", rsp_valid_o, 0);
        chk("cmd_ready_back", cmd_ready_o, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input logic bad_id,
                            input logic [1:0] bresp, input int hold,
                            input logic [1:0] er, input logic [31:0] ed);
        logic [3:0] id;
        bit aw_done, w_done, hs_aw, hs_w;
        int c;
        chk("wr_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1;
        cmd_addr_i = addr; cmd_wdata_i = data; cmd_wstrb_i = strb;
        tick();
        cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_wstrb_i = '0;
        id = exp_id; exp_id = exp_id + 4'd1; last_id = awid_o;
        chk("wr_cmd_busy", cmd_ready_o, 0);
        chk("awvalid_rise", awvalid_o, 1);
        chk("wvalid_rise", wvalid_o, 1);
        chk("wlast", wlast_o, 1);
        chk("awid", awid_o, id);
        chk("wid", wid_o, id);
        chk("awaddr", awaddr_o, addr);
        chk("wdata", wdata_o, data);
        chk("wstrb", wstrb_o, strb);
        aw_done = 0; w_done = 0; c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            awready_i = (c >= aw_dly) && !aw_done;
            wready_i  = (c >= w_dly) && !w_done;
            hs_aw = awvalid_o && awready_i;
            hs_w  = wvalid_o && wready_i;
            tick();
            c++;
            awready_i = 1'b0; wready_i = 1'b0;
            if (hs_aw) begin
                aw_done = 1;
                chk("awvalid_drop", awvalid_o, 0);
            end else if (!aw_done) begin
                chk("awvalid_hold", awvalid_o, 1);
                chk("awaddr_stable", awaddr_o, addr);
            end
            if (hs_w) begin
                w_done = 1;
                chk("wvalid_drop", wvalid_o, 0);
            end else if (!w_done) begin
                chk("wvalid_hold", wvalid_o, 1);
                chk("wdata_stable", wdata_o, data);
            end
        end
        chk("wr_handshake_bound", {30'd0, aw_done, w_done}, 3);
        chk("bready_rise", bready_o, 1);
        for (int k = 0; k < b_dly; k++) begin
            tick();
            chk("b_wait_bready", bready_o, 1);
            chk("b_wait_no_rsp", rsp_valid_o, 0);
        end
        bvalid_i = 1'b1; bid_i = bad_id ? (id ^ 4'h7) : id; bresp_i = bresp;
        tick();
        bvalid_i = 1'b0; bid_i = '0; bresp_i = '0;
        chk("bready_drop", bready_o, 0);
        finish_rsp(hold, 1'b1, er, ed);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int beats, input logic bad_id,
                           input logic [1:0] rresp, input logic [31:0] rdata, input int hold,
                           input logic [1:0] er, input logic [31:0] ed);
        logic [3:0] id;
        bit done, hs;
        int c;
        chk("rd_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = addr;
        cmd_wdata_i = 32'hFFFF_FFFF; cmd_wstrb_i = 4'hF;
        tick();
        cmd_valid_i = 1'b0; cmd_addr_i = '0;
        id = exp_id; exp_id = exp_id + 4'd1; last_id = arid_o;
        chk("arvalid_rise", arvalid_o, 1);
        chk("arid", arid_o, id);
        chk("araddr", araddr_o, addr);
        chk("rd_no_aw", awvalid_o | wvalid_o, 0);
        done = 0; c = 0;
        while (!done && c < 50) begin
            arready_i = (c >= ar_dly);
            hs = arvalid_o && arready_i;
            tick();
            c++;
            arready_i = 1'b0;
            if (hs) done = 1;
            else begin
                chk("arvalid_hold", arvalid_o, 1);
                chk("araddr_stable", araddr_o, addr);
            end
        end
        chk("ar_handshake_bound", {31'd0, done}, 1);
        chk("arvalid_drop", arvalid_o, 0);
        chk("rready_rise", rready_o, 1);
        for (int b = 0; b < beats; b++) begin
            rvalid_i = 1'b1;
            rlast_i  = (b == beats - 1);
            rdata_i  = rlast_i ? rdata : (32'hBAD0_0000 + 32'(b));
            rresp_i  = rlast_i ? rresp : 2'b11;
            rid_i    = (rlast_i && bad_id) ? (id ^ 4'h7) : id;
            tick();
            rvalid_i = 1'b0; rlast_i = 1'b0;
            if (b != beats - 1) begin
                chk("r_midburst_no_rsp", rsp_valid_o, 0);
                chk("r_midburst_rready", rready_o, 1);
            end
        end
        chk("rready_drop", rready_o, 0);
        finish_rsp(hold, 1'b0, er, ed);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h3,  32'hDEADBEEF, 4'hF, 0, 0, 0, 1, 1'b0, 2'b00, 32'h0,        0, 2'b00, 32'h0};
        vecs[1] = '{1'b1, 32'h10, 32'h12345678, 4'h3, 3, 0, 0, 1, 1'b0, 2'b00, 32'h0,        0, 2'b00, 32'h0};
        vecs[2] = '{1'b1, 32'h20, 32'hA5A5A5A5, 4'hC, 0, 2, 1, 1, 1'b0, 2'b10, 32'h0,        2, 2'b10, 32'h0};
        vecs[3] = '{1'b0, 32'h5,  32'h0,        4'h0, 0, 0, 0, 1, 1'b0, 2'b00, 32'h0000002A, 5, 2'b00, 32'h0000002A};
        vecs[4] = '{1'b0, 32'h44, 32'h0,        4'h0, 2, 0, 0, 3, 1'b0, 2'b01, 32'hCAFEF00D, 1, 2'b01, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 32'h8,  32'h11111111, 4'h1, 0, 0, 0, 1, 1'b1, 2'b00, 32'h0,        0, 2'b10, 32'h0};
        vecs[6] = '{1'b0, 32'hC,  32'h0,        4'h0, 0, 0, 0, 1, 1'b1, 2'b00, 32'h55AA55AA, 0, 2'b10, 32'h55AA55AA};
        vecs[7] = '{1'b1, 32'h30, 32'h0F0F0F0F, 4'h6, 2, 2, 3, 1, 1'b0, 2'b01, 32'h0,        1, 2'b01, 32'h0};

        cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_wstrb_i = '0;
        awready_i = 0; wready_i = 0; bid_i = '0; bresp_i = '0; bvalid_i = 0;
        arready_i = 0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 0; rvalid_i = 0;
        rsp_ready_i = 0;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we)
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].d_a, vecs[i].d_w,
                         vecs[i].d_b, vecs[i].bad_id, vecs[i].sresp, vecs[i].hold,
                         vecs[i].exp_resp, vecs[i].exp_data);
            else
                do_read(vecs[i].addr, vecs[i].d_a, vecs[i].beats, vecs[i].bad_id, vecs[i].sresp,
                        vecs[i].srdata, vecs[i].hold, vecs[i].exp_resp, vecs[i].exp_data);
        end

        // ID wrap: 16 commands use IDs 0..15, the 17th must reuse ID 0; slave answers bid 7.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i[0])
                do_read(32'(i), 0, 1, 1'b0, 2'b00, 32'(i * 3), 0, 2'b00, 32'(i * 3));
            else
                do_write(32'(i), 32'(i), 4'hF, 0, 0, 0, 1'b0, 2'b00, 0, 2'b00, 32'h0);
        end
        chk("id_before_wrap", last_id, 4'd15);
        do_write(32'h40, 32'h77, 4'hF, 0, 0, 0, 1'b1, 2'b00, 0, 2'b10, 32'h0);
        chk("id_wrap", last_id, 4'd0);

        // Reset while waiting in WR_RESP abandons the transaction.
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h9; cmd_wdata_i = 32'h99; cmd_wstrb_i = 4'hF;
        tick();
        cmd_valid_i = 1'b0;
        awready_i = 1'b1; wready_i = 1'b1;
        tick();
        awready_i = 1'b0; wready_i = 1'b0;
        chk("mid_rst_in_wr_resp", bready_o, 1);
        #2 areset = 1'b0;
        #1;
        chk("mid_rst_valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o}, 0);
        chk("mid_rst_cmd_ready", cmd_ready_o, 1);
        @(posedge clk); #1;
        areset = 1'b1;
        exp_id = 4'd0;
        bvalid_i = 1'b1; bid_i = 4'd1; bresp_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_rsp", rsp_valid_o, 0);
            chk("post_rst_cmd_ready", cmd_ready_o, 1);
        end
        bvalid_i = 1'b0; bid_i = '0;
        do_write(32'h1, 32'h5, 4'hF, 0, 0, 0, 1'b0, 2'b00, 0, 2'b00, 32'h0);
        chk("post_rst_id", last_id, 4'd0);

`ifdef M_AXI_CMD_TIMEOUT_EN
        begin
            int n;
            cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h2; cmd_wdata_i = 32'h1; cmd_wstrb_i = 4'hF;
            tick();
            cmd_valid_i = 1'b0;
            awready_i = 1'b1; wready_i = 1'b1;
            tick();
            awready_i = 1'b0; wready_i = 1'b0;
            exp_id = exp_id + 4'd1;
            chk("tmo_bready", bready_o, 1);
            n = 0;
            while (!rsp_valid_o && n < 400) begin
                tick();
                n++;
            end
            chk("tmo_cycles", n, 256);
            chk("tmo_resp", rsp_resp_o, 2'b11);
            chk("tmo_data", rsp_data_o, 0);
            chk("tmo_bready_drop", bready_o, 0);
            rsp_ready_i = 1'b1;
            tick();
            rsp_ready_i = 1'b0;
            bvalid_i = 1'b1; bid_i = 4'd2; bresp_i = 2'b00;
            tick();
            bvalid_i = 1'b0; bid_i = '0;
            chk("tmo_stale_b_ignored", rsp_valid_o, 0);
            chk("tmo_cmd_ready", cmd_ready_o, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
